// File: rtl/prog_inst_rom.sv
// Writable instruction store: registered fetch port plus a streaming program-load port.
// Define PROG_INST_ROM_CHECKSUM_EN to add an XOR checksum check on each load (LoadCsum/LoadErr).
`timescale 1ns/1ps
module prog_inst_rom #(
  parameter int unsigned       INST_W    = 9,
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DEPTH     = 512,
  parameter logic [INST_W-1:0] HALT_WORD = '1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] InstAddress,
  output logic [INST_W-1:0] InstOut,
  output logic              InstValid,
  output logic              FetchReady,
  input  logic              LoadStart,
  input  logic [ADDR_W-1:0] LoadBase,
  input  logic [ADDR_W:0]   LoadCount,
  input  logic              LoadValid,
  input  logic [INST_W-1:0] LoadData,
  output logic              LoadReady,
  output logic              LoadBusy,
  output logic              LoadDone
`ifdef PROG_INST_ROM_CHECKSUM_EN
  ,
  input  logic [INST_W-1:0] LoadCsum,
  output logic              LoadErr
`endif
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                zdone_q, zdone_d;
  logic                ivalid_q, ivalid_d;
  logic                hit_q, hit_d;
  logic [INST_W-1:0]   rdata_q;
  logic [DEPTH-1:0]    written_q;
  logic [INST_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                fetch_acc;
  logic                wr_en;
  logic [IDX_W-1:0]    fetch_idx;
  logic [IDX_W-1:0]    ptr_idx;

  assign fetch_idx = InstAddress[IDX_W-1:0];
  assign ptr_idx   = ptr_q[IDX_W-1:0];

  assign FetchReady = (state_q == S_IDLE);
  assign LoadReady  = (state_q == S_LOAD);
  assign LoadBusy   = (state_q == S_LOAD);
  assign LoadDone   = (state_q == S_FINISH) || zdone_q;
  assign InstValid  = ivalid_q;
  // A miss (out of range or never written) is folded into hit_q so the RAM read stays a plain registered read.
  assign InstOut    = hit_q ? rdata_q : HALT_WORD;

  assign accept    = LoadReady && LoadValid;
  assign fetch_acc = FetchReq && FetchReady;
  assign wr_en     = accept && ({1'b0, ptr_q} < DEPTH_L) && !Reset;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    zdone_d  = 1'b0;
    ivalid_d = 1'b0;
    hit_d    = hit_q;
    if (fetch_acc) begin
      ivalid_d = 1'b1;
      hit_d    = ({1'b0, InstAddress} < DEPTH_L) && written_q[fetch_idx];
    end
    case (state_q)
      S_IDLE: begin
        if (LoadStart) begin
          if (LoadCount != '0) begin
            state_d = S_LOAD;
            ptr_d   = LoadBase;
            rem_d   = LoadCount;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      zdone_q   <= 1'b0;
      ivalid_q  <= 1'b0;
      hit_q     <= 1'b0;
      written_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      zdone_q  <= zdone_d;
      ivalid_q <= ivalid_d;
      hit_q    <= hit_d;
      if (wr_en) written_q[ptr_idx] <= 1'b1;
    end
  end

  // Storage is deliberately not reset; validity lives in written_q.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[ptr_idx] <= LoadData;
    if (fetch_acc) rdata_q <= mem_q[fetch_idx];
  end

`ifdef PROG_INST_ROM_CHECKSUM_EN
  logic [INST_W-1:0] sum_q, sum_d;
  logic [INST_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;

  assign LoadErr = err_q;

  // The verdict is registered on the final accept so it is already valid while LoadDone is high.
  always_comb begin
    sum_d  = sum_q;
    csum_d = csum_q;
    err_d  = err_q;
    if (state_q == S_IDLE && LoadStart) begin
      sum_d  = '0;
      csum_d = LoadCsum;
      err_d  = (LoadCount == '0) ? (LoadCsum != '0) : 1'b0;
    end else if (accept) begin
      sum_d = sum_q ^ LoadData;
      if (rem_q == REM_ONE) err_d = ((sum_q ^ LoadData) != csum_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sum_q  <= '0;
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_prog_inst_rom.sv
// Randomised self-checking bench for prog_inst_rom against an array-based model of program memory.
`timescale 1ns/1ps
module tb_prog_inst_rom;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       FetchReq;
  logic [9:0] InstAddress;
  logic [8:0] InstOut;
  logic       InstValid;
  logic       FetchReady;
  logic       LoadStart;
  logic [9:0] LoadBase;
  logic [10:0] LoadCount;
  logic       LoadValid;
  logic [8:0] LoadData;
  logic       LoadReady;
  logic       LoadBusy;
  logic       LoadDone;
`ifdef PROG_INST_ROM_CHECKSUM_EN
  logic [8:0] LoadCsum;
  logic       LoadErr;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] mdat [1024];
  bit         mwr  [1024];
  logic [8:0] ld_q [$];

  prog_inst_rom #(.INST_W(9), .ADDR_W(10), .DEPTH(512), .HALT_WORD(9'h1FF)) dut (
    .Clk(Clk), .Reset(Reset), .FetchReq(FetchReq), .InstAddress(InstAddress),
    .InstOut(InstOut), .InstValid(InstValid), .FetchReady(FetchReady),
    .LoadStart(LoadStart), .LoadBase(LoadBase), .LoadCount(LoadCount),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadReady(LoadReady),
    .LoadBusy(LoadBusy), .LoadDone(LoadDone)
`ifdef PROG_INST_ROM_CHECKSUM_EN
    , .LoadCsum(LoadCsum), .LoadErr(LoadErr)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 1024; i++) mwr[i] = 1'b0;
  endfunction

  function automatic logic [8:0] model_read(input logic [9:0] a);
    if (a >= 10'd512 || !mwr[a]) return 9'h1FF;
    return mdat[a];
  endfunction

  function automatic void model_write(input logic [9:0] a, input logic [8:0] w);
    if (a < 10'd512) begin
      mdat[a] = w;
      mwr[a]  = 1'b1;
    end
  endfunction

  task automatic fetch(input logic [9:0] a, output logic v, output logic [8:0] d);
    FetchReq    = 1'b1;
    InstAddress = a;
    tick();
    v = InstValid;
    d = InstOut;
    FetchReq = 1'b0;
  endtask

  // Drives a full load and reports protocol observations; words come from ld_q, else random.
  task automatic run_load(input logic [9:0] base, input logic [10:0] count, input int gapmax,
                          input logic [8:0] csum, output int proto_bad, output bit done_ok,
                          output bit ready_back, output logic err_seen);
    logic [8:0] w;
    logic [9:0] a;
    int n;
    n = int'(count);
    proto_bad = 0;
    FetchReq = 1'b0;
    LoadStart = 1'b1;
    LoadBase = base;
    LoadCount = count;
`ifdef PROG_INST_ROM_CHECKSUM_EN
    LoadCsum = csum;
`else
    if (csum != 9'h000) proto_bad = proto_bad + 0;
`endif
    tick();
    LoadStart = 1'b0;
    FetchReq = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = (ld_q.size() > 0) ? ld_q.pop_front() : 9'($urandom);
      repeat ($urandom_range(gapmax, 0)) begin
        LoadValid = 1'b0;
        InstAddress = 10'($urandom);
        tick();
        if (!(InstValid === 1'b0 && FetchReady === 1'b0 && LoadBusy === 1'b1 &&
              LoadReady === 1'b1 && LoadDone === 1'b0)) proto_bad++;
      end
      LoadValid = 1'b1;
      LoadData = w;
      InstAddress = 10'($urandom);
      tick();
      a = base + 10'(i);
      model_write(a, w);
      if (i < n - 1 && !(InstValid === 1'b0 && FetchReady === 1'b0 && LoadBusy === 1'b1 &&
                         LoadDone === 1'b0)) proto_bad++;
    end
    LoadValid = 1'b0;
    done_ok = (LoadDone === 1'b1 && LoadBusy === 1'b0 && FetchReady === 1'b0 && InstValid === 1'b0);
`ifdef PROG_INST_ROM_CHECKSUM_EN
    err_seen = LoadErr;
`else
    err_seen = 1'b0;
`endif
    tick();
    ready_back = (FetchReady === 1'b1 && LoadDone === 1'b0 && InstValid === 1'b0);
    FetchReq = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    Reset = 1'b1; FetchReq = 1'b0; InstAddress = '0; LoadStart = 1'b0; LoadBase = '0;
    LoadCount = '0; LoadValid = 1'b0; LoadData = '0;
`ifdef PROG_INST_ROM_CHECKSUM_EN
    LoadCsum = '0;
`endif
    tick(); tick();
    model_clear();
    obs = {InstOut, InstValid, FetchReady, LoadReady, LoadBusy, LoadDone};
    vectors++;
    if (obs !== {9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want %h", obs, {9'h1FF, 5'b01000});
    end
`ifdef PROG_INST_ROM_CHECKSUM_EN
    vectors++;
    if (LoadErr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_loaderr got %b want 0", LoadErr);
    end
`endif
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_halt();
    logic v;
    logic [8:0] d;
    logic [9:0] addrs [$];
    addrs = {10'd0, 10'd600, 10'd511, 10'd512, 10'd1023};
    for (int i = 0; i < 5; i++) addrs.push_back(10'($urandom));
    foreach (addrs[i]) begin
      fetch(addrs[i], v, d);
      vectors++;
      if ({v, d} !== {1'b1, 9'h1FF}) begin
        miscompares++;
        $display("FAIL halt_fetch addr=%0d got v=%b d=%h want v=1 d=1ff", addrs[i], v, d);
      end
    end
    tick();
    vectors++;
    if (InstValid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_valid_drop got %b want 0", InstValid);
    end
  endtask

  task automatic test_load_basic();
    int pb; bit dk, rb; logic e; logic v; logic [8:0] d;
    ld_q = {9'h000, 9'h180, 9'h1E0};
    run_load(10'd4, 11'd3, 3, 9'h000, pb, dk, rb, e);
    vectors++;
    if ({pb != 0, dk, rb} !== 3'b011) begin
      miscompares++;
      $display("FAIL basic_load_proto got bad=%0d done=%b ready=%b want 0 1 1", pb, dk, rb);
    end
    for (int a = 4; a <= 7; a++) begin
      fetch(10'(a), v, d);
      vectors++;
      if ({v, d} !== {1'b1, model_read(10'(a))}) begin
        miscompares++;
        $display("FAIL basic_fetch addr=%0d got %b/%h want 1/%h", a, v, d, model_read(10'(a)));
      end
    end
  endtask

  task automatic test_depth_edge();
    int pb; bit dk, rb; logic e; logic v; logic [8:0] d;
    run_load(10'd510, 11'd4, 2, 9'h000, pb, dk, rb, e);
    vectors++;
    if ({pb != 0, dk, rb} !== 3'b011) begin
      miscompares++;
      $display("FAIL depth_load_proto got bad=%0d done=%b ready=%b want 0 1 1", pb, dk, rb);
    end
    for (int a = 509; a <= 514; a++) begin
      fetch(10'(a), v, d);
      vectors++;
      if ({v, d} !== {1'b1, model_read(10'(a))}) begin
        miscompares++;
        $display("FAIL depth_fetch addr=%0d got %b/%h want 1/%h", a, v, d, model_read(10'(a)));
      end
    end
  endtask

  task automatic test_random_loads();
    int pb; bit dk, rb; logic e; logic v; logic [8:0] d;
    logic [9:0] base, a;
    logic [10:0] cnt;
    for (int k = 0; k < 6; k++) begin
      base = (k == 0) ? 10'd1021 : 10'($urandom_range(530, 0));
      cnt  = 11'($urandom_range(12, 1));
      run_load(base, cnt, 2, 9'h000, pb, dk, rb, e);
      vectors++;
      if ({pb != 0, dk, rb} !== 3'b011) begin
        miscompares++;
        $display("FAIL rand_load_proto base=%0d cnt=%0d got bad=%0d done=%b ready=%b", base, cnt, pb, dk, rb);
      end
      for (int j = 0; j < 6; j++) begin
        a = (j < 4) ? base + 10'($urandom_range(int'(cnt) - 1, 0)) : 10'($urandom);
        fetch(a, v, d);
        vectors++;
        if ({v, d} !== {1'b1, model_read(a)}) begin
          miscompares++;
          $display("FAIL rand_fetch addr=%0d got %b/%h want 1/%h", a, v, d, model_read(a));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] pool [$];
    logic [9:0] a;
    logic [8:0] last;
    pool = {10'd4, 10'd5, 10'd6, 10'd7, 10'd510, 10'd511, 10'd512, 10'd0, 10'd1022};
    last = 9'h1FF;
    FetchReq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = pool[$urandom_range(pool.size() - 1, 0)];
      if (i == 15) a = 10'd5;
      InstAddress = a;
      tick();
      last = model_read(a);
      vectors++;
      if ({InstValid, InstOut} !== {1'b1, last}) begin
        miscompares++;
        $display("FAIL b2b_fetch addr=%0d got %b/%h want 1/%h", a, InstValid, InstOut, last);
      end
    end
    FetchReq = 1'b0;
    InstAddress = 10'd600;
    tick();
    vectors++;
    if ({InstValid, InstOut} !== {1'b0, last}) begin
      miscompares++;
      $display("FAIL b2b_hold got %b/%h want 0/%h", InstValid, InstOut, last);
    end
  endtask

  task automatic test_fetch_with_start();
    logic [8:0] old, nw;
    logic v; logic [8:0] d;
    old = model_read(10'd5);
    nw = old ^ 9'h0F3;
    FetchReq = 1'b1; InstAddress = 10'd5;
    LoadStart = 1'b1; LoadBase = 10'd5; LoadCount = 11'd1;
    tick();
    FetchReq = 1'b0; LoadStart = 1'b0;
    vectors++;
    if ({InstValid, InstOut, LoadBusy} !== {1'b1, old, 1'b1}) begin
      miscompares++;
      $display("FAIL fetch_start_same got %b/%h/%b want 1/%h/1", InstValid, InstOut, LoadBusy, old);
    end
    LoadValid = 1'b1; LoadData = nw;
    tick();
    LoadValid = 1'b0;
    model_write(10'd5, nw);
    vectors++;
    if (LoadDone !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_start_done got %b want 1", LoadDone);
    end
    tick();
    fetch(10'd5, v, d);
    vectors++;
    if ({v, d} !== {1'b1, nw}) begin
      miscompares++;
      $display("FAIL fetch_start_new got %b/%h want 1/%h", v, d, nw);
    end
  endtask

  task automatic test_start_ignored();
    logic [8:0] wa, wb;
    logic v; logic [8:0] d;
    logic [9:0] chk [3];
    wa = 9'($urandom); wb = 9'($urandom);
    LoadStart = 1'b1; LoadBase = 10'd200; LoadCount = 11'd2;
    tick();
    LoadBase = 10'd300; LoadCount = 11'd5;
    LoadValid = 1'b1; LoadData = wa;
    tick();
    LoadStart = 1'b0; LoadData = wb;
    tick();
    LoadValid = 1'b0;
    model_write(10'd200, wa); model_write(10'd201, wb);
    vectors++;
    if (LoadDone !== 1'b1) begin
      miscompares++;
      $display("FAIL ignored_start_done got %b want 1", LoadDone);
    end
    tick();
    chk = '{10'd200, 10'd201, 10'd300};
    foreach (chk[i]) begin
      fetch(chk[i], v, d);
      vectors++;
      if ({v, d} !== {1'b1, model_read(chk[i])}) begin
        miscompares++;
        $display("FAIL ignored_start_fetch addr=%0d got %b/%h want 1/%h", chk[i], v, d, model_read(chk[i]));
      end
    end
  endtask

  task automatic test_reset_midload();
    int dones;
    logic v; logic [8:0] d;
    LoadStart = 1'b1; LoadBase = 10'd100; LoadCount = 11'd5;
    tick();
    LoadStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      LoadValid = 1'b1; LoadData = 9'($urandom);
      tick();
    end
    Reset = 1'b1; LoadData = 9'($urandom);
    tick();
    Reset = 1'b0; LoadValid = 1'b0;
    model_clear();
    vectors++;
    if ({LoadBusy, FetchReady, LoadDone, LoadReady} !== 4'b0100) begin
      miscompares++;
      $display("FAIL midreset_state got %b want 0100", {LoadBusy, FetchReady, LoadDone, LoadReady});
    end
    dones = 0;
    repeat (4) begin
      tick();
      if (LoadDone !== 1'b0) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midreset_nodone got %0d pulses want 0", dones);
    end
    fetch(10'd100, v, d);
    vectors++;
    if ({v, d} !== {1'b1, 9'h1FF}) begin
      miscompares++;
      $display("FAIL midreset_fetch_base got %b/%h want 1/1ff", v, d);
    end
    fetch(10'd4, v, d);
    vectors++;
    if ({v, d} !== {1'b1, 9'h1FF}) begin
      miscompares++;
      $display("FAIL midreset_fetch_old got %b/%h want 1/1ff", v, d);
    end
  endtask

  task automatic test_zero_count();
    LoadStart = 1'b1; LoadBase = 10'd50; LoadCount = 11'd0;
`ifdef PROG_INST_ROM_CHECKSUM_EN
    LoadCsum = 9'h000;
`endif
    tick();
    LoadStart = 1'b0;
    vectors++;
    if ({LoadDone, FetchReady, LoadBusy, LoadReady} !== 4'b1100) begin
      miscompares++;
      $display("FAIL zero_done got %b want 1100", {LoadDone, FetchReady, LoadBusy, LoadReady});
    end
    tick();
    vectors++;
    if ({LoadDone, FetchReady} !== 2'b01) begin
      miscompares++;
      $display("FAIL zero_after got %b want 01", {LoadDone, FetchReady});
    end
  endtask

`ifdef PROG_INST_ROM_CHECKSUM_EN
  task automatic test_checksum();
    int pb; bit dk, rb; logic e;
    logic [8:0] cs [2];
    bit want [2];
    cs = '{9'h0FF, 9'h000};
    want = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      ld_q = {9'h0A5, 9'h05A};
      run_load(10'd20, 11'd2, 2, cs[k], pb, dk, rb, e);
      vectors++;
      if ({e, LoadErr, dk, rb} !== {want[k], want[k], 2'b11}) begin
        miscompares++;
        $display("FAIL csum_load%0d got err=%b held=%b done=%b want %b", k, e, LoadErr, dk, want[k]);
      end
    end
    LoadStart = 1'b1; LoadCount = 11'd0; LoadCsum = 9'h001;
    tick();
    LoadStart = 1'b0;
    vectors++;
    if ({LoadDone, LoadErr} !== 2'b11) begin
      miscompares++;
      $display("FAIL csum_zero_len got %b want 11", {LoadDone, LoadErr});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_halt();
    test_load_basic();
    test_depth_edge();
    test_random_loads();
    test_back_to_back();
    test_fetch_with_start();
    test_start_ignored();
    test_zero_count();
`ifdef PROG_INST_ROM_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
